// File: rtl/rob_fill_pkg.sv
// Shared types, default widths and the round-robin pointer update for the
// ROB fill responder.
package rob_fill_pkg;

  localparam int unsigned RF_NUM_SRC   = 3;
  localparam int unsigned RF_ROB_DEPTH = 16;
  localparam int unsigned RF_IDX_W     = 4;
  localparam int unsigned RF_DATA_W    = 32;
  localparam int unsigned RF_PTR_W     = 2;

  typedef struct packed {
    logic [RF_IDX_W-1:0]  idx;
    logic [RF_DATA_W-1:0] data;
    logic                 exc;
  } fill_req_t;

  // Pointer moves to the source after the granted one; holds with no grant.
  function automatic logic [RF_PTR_W-1:0] rr_next(input logic [RF_PTR_W-1:0] ptr,
                                                  input logic [RF_NUM_SRC-1:0] grant);
    logic [RF_PTR_W-1:0] nxt;
    nxt = ptr;
    for (int unsigned i = 0; i < RF_NUM_SRC; i++) begin
      if (grant[i]) nxt = (i == RF_NUM_SRC - 1) ? '0 : RF_PTR_W'(i + 1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rob_fill_responder_rr_arb.sv
// Round-robin arbiter: search starts at ptr and wraps NUM_SRC-1 -> 0.
module rob_fill_rr_arb
  import rob_fill_pkg::*;
#(
  parameter int unsigned NUM_SRC = RF_NUM_SRC,
  parameter int unsigned PTR_W   = RF_PTR_W
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               grant_vld
);

  // First requester at or after the pointer wins.
  always_comb begin
    int unsigned cand;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      cand = (32'(ptr) + k) % NUM_SRC;
      if (!grant_vld && req[PTR_W'(cand)]) begin
        grant[PTR_W'(cand)] = 1'b1;
        grant_idx           = PTR_W'(cand);
        grant_vld           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rob_fill_responder.sv
// ROB-side fill responder: round-robin acceptance of execution results,
// registered ROB write port, sticky error on fills to unallocated entries.
// Optional per-source stall counters when ROB_FILL_STATS_EN is defined.
module rob_fill_responder
  import rob_fill_pkg::*;
#(
  parameter int unsigned NUM_SRC   = RF_NUM_SRC,
  parameter int unsigned ROB_DEPTH = RF_ROB_DEPTH,
  parameter int unsigned IDX_W     = RF_IDX_W,
  parameter int unsigned DATA_W    = RF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        fill_req,
  input  logic [NUM_SRC*IDX_W-1:0]  fill_idx,
  input  logic [NUM_SRC*DATA_W-1:0] fill_data,
  input  logic [NUM_SRC-1:0]        fill_exc,
  output logic [NUM_SRC-1:0]        fill_ack,
  input  logic [ROB_DEPTH-1:0]      rob_alloc_mask,
  output logic                      rob_wr_en,
  output logic [IDX_W-1:0]          rob_wr_idx,
  output logic [DATA_W-1:0]         rob_wr_data,
  output logic                      rob_wr_exc,
  output logic                      fill_err
`ifdef ROB_FILL_STATS_EN
  ,
  output logic [NUM_SRC*16-1:0]     stall_cnt
`endif
);

  localparam int unsigned PTR_W = RF_PTR_W;

  logic [PTR_W-1:0]   ptr;
  logic [NUM_SRC-1:0] arb_req;
  logic [NUM_SRC-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_vld;
  fill_req_t          sel;
  fill_req_t          wr_q;
  logic               wr_en_q;
  logic               alloc_ok;

  assign arb_req = fill_req & ~{NUM_SRC{flush}};

  rob_fill_rr_arb #(
    .NUM_SRC (NUM_SRC),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req       (arb_req),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign fill_ack = grant & {NUM_SRC{rst_n}};

  // Mux the granted source's payload and check its target entry.
  always_comb begin
    sel      = '0;
    sel.idx  = fill_idx[grant_idx*IDX_W +: IDX_W];
    sel.data = fill_data[grant_idx*DATA_W +: DATA_W];
    sel.exc  = fill_exc[grant_idx];
    alloc_ok = rob_alloc_mask[sel.idx];
  end

  // Pointer, write stage and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      wr_en_q  <= 1'b0;
      wr_q     <= '0;
      fill_err <= 1'b0;
    end else begin
      wr_en_q <= grant_vld && alloc_ok;
      if (grant_vld) begin
        ptr  <= rr_next(ptr, grant);
        wr_q <= sel;
        if (!alloc_ok) fill_err <= 1'b1;
      end
    end
  end

  // Flush kills the write already sitting in the output stage.
  assign rob_wr_en   = wr_en_q && !flush;
  assign rob_wr_idx  = wr_q.idx;
  assign rob_wr_data = wr_q.data;
  assign rob_wr_exc  = wr_q.exc;

`ifdef ROB_FILL_STATS_EN
  // Saturating count of cycles each source waited with a request up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (fill_req[i] && !fill_ack[i] && stall_cnt[i*16 +: 16] != 16'hFFFF)
          stall_cnt[i*16 +: 16] <= stall_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rob_fill_responder.sv
// Directed self-checking bench for rob_fill_responder.
// Inputs change on the falling edge; everything is checked 1 time unit later.
module tb_rob_fill_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [2:0]  fill_req;
  logic [11:0] fill_idx;
  logic [95:0] fill_data;
  logic [2:0]  fill_exc;
  logic [2:0]  fill_ack;
  logic [15:0] rob_alloc_mask;
  logic        rob_wr_en;
  logic [3:0]  rob_wr_idx;
  logic [31:0] rob_wr_data;
  logic        rob_wr_exc;
  logic        fill_err;
`ifdef ROB_FILL_STATS_EN
  logic [47:0] stall_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rob_fill_responder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .fill_req       (fill_req),
    .fill_idx       (fill_idx),
    .fill_data      (fill_data),
    .fill_exc       (fill_exc),
    .fill_ack       (fill_ack),
    .rob_alloc_mask (rob_alloc_mask),
    .rob_wr_en      (rob_wr_en),
    .rob_wr_idx     (rob_wr_idx),
    .rob_wr_data    (rob_wr_data),
    .rob_wr_exc     (rob_wr_exc),
    .fill_err       (fill_err)
`ifdef ROB_FILL_STATS_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  task automatic set_src(input int unsigned s, input logic [3:0] idx,
                         input logic [31:0] data, input logic exc);
    fill_idx[s*4 +: 4]   = idx;
    fill_data[s*32 +: 32] = data;
    fill_exc[s]          = exc;
    fill_req[s]          = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; fill_req = 3'b111;
    fill_idx = '0; fill_data = '0; fill_exc = '0; rob_alloc_mask = 16'hFFFF;
    #3;
    vectors++; if (fill_ack !== 3'b000) begin miscompares++; $display("FAIL reset_ack: got %b exp 000", fill_ack); end
    vectors++; if (rob_wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en: got %b exp 0", rob_wr_en); end
    vectors++; if (rob_wr_idx !== 4'd0) begin miscompares++; $display("FAIL reset_wr_idx: got %0d exp 0", rob_wr_idx); end
    vectors++; if (rob_wr_data !== 32'd0) begin miscompares++; $display("FAIL reset_wr_data: got %h exp 0", rob_wr_data); end
    vectors++; if (rob_wr_exc !== 1'b0) begin miscompares++; $display("FAIL reset_wr_exc: got %b exp 0", rob_wr_exc); end
    vectors++; if (fill_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b exp 0", fill_err); end
    @(negedge clk); rst_n = 1'b1; fill_req = 3'b000;
  endtask

  task automatic test_single();
    @(negedge clk); set_src(0, 4'd5, 32'hDEAD_BEEF, 1'b0); #1;
    vectors++; if (fill_ack !== 3'b001) begin miscompares++; $display("FAIL single_ack: got %b exp 001", fill_ack); end
    @(negedge clk); fill_req = 3'b000; #1;
    vectors++; if (rob_wr_en !== 1'b1) begin miscompares++; $display("FAIL single_wr_en: got %b exp 1", rob_wr_en); end
    vectors++; if (rob_wr_idx !== 4'd5) begin miscompares++; $display("FAIL single_wr_idx: got %0d exp 5", rob_wr_idx); end
    vectors++; if (rob_wr_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL single_wr_data: got %h exp deadbeef", rob_wr_data); end
    vectors++; if (rob_wr_exc !== 1'b0) begin miscompares++; $display("FAIL single_wr_exc: got %b exp 0", rob_wr_exc); end
  endtask

  // Pointer sits at 1 after the single fill; a lone src2 grant returns it to 0.
  task automatic test_round_robin();
    logic [31:0] d [3];
    logic [3:0]  x [3];
    int unsigned ws;
    d[0] = 32'h0000_00A0; d[1] = 32'h0000_00B1; d[2] = 32'h0000_00C2;
    x[0] = 4'd1; x[1] = 4'd2; x[2] = 4'd3;
    @(negedge clk); set_src(2, x[2], d[2], 1'b1); #1;
    vectors++; if (fill_ack !== 3'b100) begin miscompares++; $display("FAIL rr_pre_ack: got %b exp 100", fill_ack); end
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k < 6) begin
        set_src(0, x[0], d[0], 1'b0);
        set_src(1, x[1], d[1], 1'b0);
        set_src(2, x[2], d[2], 1'b1);
      end else begin
        fill_req = 3'b000;
      end
      #1;
      ws = (k + 2) % 3;
      vectors++;
      if (fill_ack !== ((k < 6) ? (3'b001 << (k % 3)) : 3'b000)) begin
        miscompares++; $display("FAIL rr_ack[%0d]: got %b exp %b", k, fill_ack, (k < 6) ? (3'b001 << (k % 3)) : 3'b000);
      end
      vectors++;
      if (rob_wr_en !== 1'b1 || rob_wr_idx !== x[ws] || rob_wr_data !== d[ws] || rob_wr_exc !== (ws == 2)) begin
        miscompares++; $display("FAIL rr_wr[%0d]: got en=%b idx=%0d data=%h exc=%b exp src%0d", k, rob_wr_en, rob_wr_idx, rob_wr_data, rob_wr_exc, ws);
      end
    end
  endtask

  task automatic test_flush();
    @(negedge clk); set_src(0, 4'd4, 32'h44, 1'b0); set_src(1, 4'd6, 32'h66, 1'b0); #1;
    vectors++; if (fill_ack !== 3'b001) begin miscompares++; $display("FAIL flush_n_ack: got %b exp 001", fill_ack); end
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk); fill_req = 3'b010; flush = 1'b1; #1;
      vectors++; if (fill_ack !== 3'b000) begin miscompares++; $display("FAIL flush_ack[%0d]: got %b exp 000", c, fill_ack); end
      vectors++; if (rob_wr_en !== 1'b0) begin miscompares++; $display("FAIL flush_wr_en[%0d]: got %b exp 0", c, rob_wr_en); end
    end
    @(negedge clk); flush = 1'b0; #1;
    vectors++; if (fill_ack !== 3'b010) begin miscompares++; $display("FAIL flush_after_ack: got %b exp 010", fill_ack); end
    vectors++; if (rob_wr_en !== 1'b0) begin miscompares++; $display("FAIL flush_after_wr_en: got %b exp 0", rob_wr_en); end
    @(negedge clk); fill_req = 3'b000; #1;
    vectors++; if (rob_wr_en !== 1'b1 || rob_wr_idx !== 4'd6 || rob_wr_data !== 32'h66) begin
      miscompares++; $display("FAIL flush_src1_wr: got en=%b idx=%0d data=%h exp 1/6/66", rob_wr_en, rob_wr_idx, rob_wr_data);
    end
  endtask

  task automatic test_unalloc();
    @(negedge clk); rob_alloc_mask = 16'hFDFF; set_src(0, 4'd9, 32'h99, 1'b0); #1;
    vectors++; if (fill_ack !== 3'b001) begin miscompares++; $display("FAIL unalloc_ack: got %b exp 001", fill_ack); end
    vectors++; if (fill_err !== 1'b0) begin miscompares++; $display("FAIL unalloc_err_early: got %b exp 0", fill_err); end
    @(negedge clk); fill_req = 3'b000; #1;
    vectors++; if (rob_wr_en !== 1'b0) begin miscompares++; $display("FAIL unalloc_wr_en: got %b exp 0", rob_wr_en); end
    vectors++; if (fill_err !== 1'b1) begin miscompares++; $display("FAIL unalloc_err: got %b exp 1", fill_err); end
    @(negedge clk); set_src(1, 4'd7, 32'h77, 1'b0); #1;
    vectors++; if (fill_ack !== 3'b010) begin miscompares++; $display("FAIL unalloc_next_ack: got %b exp 010", fill_ack); end
    @(negedge clk); fill_req = 3'b000; rob_alloc_mask = 16'hFFFF; #1;
    vectors++; if (rob_wr_en !== 1'b1 || rob_wr_idx !== 4'd7) begin
      miscompares++; $display("FAIL unalloc_next_wr: got en=%b idx=%0d exp 1/7", rob_wr_en, rob_wr_idx);
    end
    vectors++; if (fill_err !== 1'b1) begin miscompares++; $display("FAIL unalloc_err_sticky: got %b exp 1", fill_err); end
  endtask

  task automatic test_same_idx();
    @(negedge clk); set_src(2, 4'd3, 32'h222, 1'b0); #1;
    vectors++; if (fill_ack !== 3'b100) begin miscompares++; $display("FAIL same_a_ack: got %b exp 100", fill_ack); end
    @(negedge clk); fill_req = 3'b000; set_src(0, 4'd3, 32'h333, 1'b0); #1;
    vectors++; if (fill_ack !== 3'b001) begin miscompares++; $display("FAIL same_b_ack: got %b exp 001", fill_ack); end
    vectors++; if (rob_wr_en !== 1'b1 || rob_wr_idx !== 4'd3 || rob_wr_data !== 32'h222) begin
      miscompares++; $display("FAIL same_a_wr: got en=%b idx=%0d data=%h exp 1/3/222", rob_wr_en, rob_wr_idx, rob_wr_data);
    end
    @(negedge clk); fill_req = 3'b000; #1;
    vectors++; if (rob_wr_en !== 1'b1 || rob_wr_idx !== 4'd3 || rob_wr_data !== 32'h333) begin
      miscompares++; $display("FAIL same_b_wr: got en=%b idx=%0d data=%h exp 1/3/333", rob_wr_en, rob_wr_idx, rob_wr_data);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk); set_src(1, 4'd8, 32'h88, 1'b0); #1;
    vectors++; if (fill_ack !== 3'b010) begin miscompares++; $display("FAIL areset_pre_ack: got %b exp 010", fill_ack); end
    @(negedge clk); fill_req = 3'b100; #1;
    vectors++; if (rob_wr_en !== 1'b1) begin miscompares++; $display("FAIL areset_pending: got %b exp 1", rob_wr_en); end
    #1; rst_n = 1'b0; #1;
    vectors++; if (rob_wr_en !== 1'b0 || rob_wr_data !== 32'd0 || fill_err !== 1'b0) begin
      miscompares++; $display("FAIL areset_drop: got en=%b data=%h err=%b exp 0/0/0", rob_wr_en, rob_wr_data, fill_err);
    end
    vectors++; if (fill_ack !== 3'b000) begin miscompares++; $display("FAIL areset_ack: got %b exp 000", fill_ack); end
    @(negedge clk); rst_n = 1'b1; fill_req = 3'b000;
    set_src(0, 4'd1, 32'h1, 1'b0); set_src(1, 4'd2, 32'h2, 1'b0); set_src(2, 4'd3, 32'h3, 1'b0); #1;
    vectors++; if (fill_ack !== 3'b001) begin miscompares++; $display("FAIL areset_ptr: got %b exp 001", fill_ack); end
    @(negedge clk); fill_req = 3'b000;
  endtask

`ifdef ROB_FILL_STATS_EN
  task automatic test_stats();
    @(negedge clk); rst_n = 1'b0; fill_req = 3'b000;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); flush = 1'b1;
    set_src(0, 4'd1, 32'h1, 1'b0); set_src(1, 4'd2, 32'h2, 1'b0); set_src(2, 4'd3, 32'h3, 1'b0);
    @(negedge clk);
    @(negedge clk); flush = 1'b0; #1;
    vectors++; if (fill_ack !== 3'b001) begin miscompares++; $display("FAIL stats_ack0: got %b exp 001", fill_ack); end
    @(negedge clk); fill_req[0] = 1'b0; #1;
    vectors++; if (fill_ack !== 3'b010) begin miscompares++; $display("FAIL stats_ack1: got %b exp 010", fill_ack); end
    @(negedge clk); fill_req[1] = 1'b0; #1;
    vectors++; if (fill_ack !== 3'b100) begin miscompares++; $display("FAIL stats_ack2: got %b exp 100", fill_ack); end
    vectors++; if (stall_cnt[47:32] !== 16'd4) begin miscompares++; $display("FAIL stats_cnt2: got %0d exp 4", stall_cnt[47:32]); end
    vectors++; if (stall_cnt[31:16] !== 16'd3) begin miscompares++; $display("FAIL stats_cnt1: got %0d exp 3", stall_cnt[31:16]); end
    vectors++; if (stall_cnt[15:0] !== 16'd2) begin miscompares++; $display("FAIL stats_cnt0: got %0d exp 2", stall_cnt[15:0]); end
    @(negedge clk); fill_req = 3'b000; #1;
    vectors++; if (stall_cnt[47:32] !== 16'd4) begin miscompares++; $display("FAIL stats_cnt2_hold: got %0d exp 4", stall_cnt[47:32]); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_flush();
    test_unalloc();
    test_same_idx();
    test_async_reset();
`ifdef ROB_FILL_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
